piso_serializer: RTL and testbench

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/serializer_pkg.sv | 14 +
 rtl/bit_counter.sv | 32 +++
 rtl/piso_serializer.sv | 118 +++++++++++
 tb/tb_piso_serializer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serializer_pkg.sv
// Shared definitions for the parallel-in serial-out serializer: default parameters and FSM
// encoding.
package serializer_pkg;

  localparam int unsigned DefWidth     = 8;
  localparam bit          DefMsbFirst  = 1'b1;
  localparam bit          DefIdleLevel = 1'b0;

  typedef enum logic {
    StIdle  = 1'b0,
    StShift = 1'b1
  } state_e;

endpackage

// File: rtl/bit_counter.sv
// Bit-position counter for the serializer.
// Clear wins over enable. The count wraps to zero after reaching the terminal count.
module bit_counter #(
  parameter int unsigned  WIDTH = 8,
  localparam int unsigned CntW  = $clog2(WIDTH)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            clr,
  input  logic            en,
  output logic [CntW-1:0] count,
  output logic            tc
);

  localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tc ? '0 : cnt_q + CntW'(1);
    end
  end

  assign count = cnt_q;
  assign tc    = (cnt_q == CntMax);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with a valid/ready word input and a bit-rate enable.
// ser_out, ser_valid and ser_last come straight from flops. in_ready also depends on ser_en.
module piso_serializer
  import serializer_pkg::*;
#(
  parameter int unsigned WIDTH      = DefWidth,
  parameter bit          MSB_FIRST  = DefMsbFirst,
  parameter bit          IDLE_LEVEL = DefIdleLevel
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             ser_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last
);

  localparam int unsigned     CntW   = $clog2(WIDTH);
  localparam logic [CntW-1:0] PenMax = CntW'(WIDTH - 2);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d, shifted;
  logic             out_q, out_d;
  logic             last_q, last_d;
  logic             live_q;
  logic [CntW-1:0]  count;
  logic             tc;
  logic             hs;
  logic             advance;

  function automatic logic head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  assign hs      = in_valid & in_ready;
  assign advance = (state_q == StShift) & ser_en;
  assign shifted = MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);

  bit_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk  (clk),
    .rstn (rstn),
    .clr  (hs),
    .en   (advance),
    .count(count),
    .tc   (tc)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (hs) state_d = StShift;
      StShift: if (advance && tc && !hs) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // live_q keeps in_ready low until the first edge after reset release.
  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      StIdle:  in_ready = live_q;
      StShift: in_ready = tc & ser_en;
      default: in_ready = 1'b0;
    endcase
  end

  always_comb begin
    sreg_d = sreg_q;
    out_d  = out_q;
    last_d = last_q;
    if (hs) begin
      sreg_d = in_data;
      out_d  = head(in_data);
      last_d = 1'b0;
    end else if (advance) begin
      if (tc) begin
        out_d  = IDLE_LEVEL;
        last_d = 1'b0;
      end else begin
        sreg_d = shifted;
        out_d  = head(shifted);
        last_d = (count == PenMax);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sreg_q <= '0;
      out_q  <= IDLE_LEVEL;
      last_q <= 1'b0;
      live_q <= 1'b0;
    end else begin
      sreg_q <= sreg_d;
      out_q  <= out_d;
      last_q <= last_d;
      live_q <= 1'b1;
    end
  end

  assign ser_out   = out_q;
  assign ser_valid = (state_q == StShift);
  assign ser_last  = last_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: MSB-first and LSB-first instances, with an
// expected-bit scoreboard drained at each falling edge.
module tb_piso_serializer;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       ser_en = 1'b1;
  logic       valid_m = 1'b0, valid_l = 1'b0;
  logic [7:0] data_m = '0, data_l = '0;
  logic       ready_m, ready_l;
  logic       out_m, out_l, sv_m, sv_l, last_m, last_l;

  exp_t q_m[$];
  exp_t q_l[$];
  int   checks = 0;
  int   failures = 0;
  int   vcnt_m = 0, lcnt_m = 0, vcnt_l = 0, lcnt_l = 0;
  int   run_m = 0, maxrun_m = 0;
  bit   mon_en = 1'b0;

  piso_serializer dut_m (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (valid_m),
    .in_data  (data_m),
    .in_ready (ready_m),
    .ser_en   (ser_en),
    .ser_out  (out_m),
    .ser_valid(sv_m),
    .ser_last (last_m)
  );

  piso_serializer #(
    .MSB_FIRST(1'b0)
  ) dut_l (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (valid_l),
    .in_data  (data_l),
    .in_ready (ready_l),
    .ser_en   (ser_en),
    .ser_out  (out_l),
    .ser_valid(sv_l),
    .ser_last (last_l)
  );

  initial forever #5 clk = ~clk;

  // Scoreboard consumer: peek every valid cycle, pop when ser_en lets the bit advance.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        checks++;
        if (sv_m) begin
          vcnt_m++;
          run_m++;
          if (run_m > maxrun_m) maxrun_m = run_m;
          if (last_m) lcnt_m++;
          if (q_m.size() == 0) begin
            failures++;
            $display("FAIL msb_extra_bit ser_valid=1 with no expected bit");
          end else begin
            e = q_m[0];
            if ({out_m, last_m} !== {e.b, e.last}) begin
              failures++;
              $display("FAIL msb_bit out=%b last=%b required out=%b last=%b at %0t",
                       out_m, last_m, e.b, e.last, $time);
            end
            if (ser_en) void'(q_m.pop_front());
          end
        end else begin
          run_m = 0;
          if ({out_m, last_m} !== 2'b00) begin
            failures++;
            $display("FAIL msb_idle out=%b last=%b required 0 0 at %0t", out_m, last_m, $time);
          end
        end
        checks++;
        if (sv_l) begin
          vcnt_l++;
          if (last_l) lcnt_l++;
          if (q_l.size() == 0) begin
            failures++;
            $display("FAIL lsb_extra_bit ser_valid=1 with no expected bit");
          end else begin
            e = q_l[0];
            if ({out_l, last_l} !== {e.b, e.last}) begin
              failures++;
              $display("FAIL lsb_bit out=%b last=%b required out=%b last=%b at %0t",
                       out_l, last_l, e.b, e.last, $time);
            end
            if (ser_en) void'(q_l.pop_front());
          end
        end else if ({out_l, last_l} !== 2'b00) begin
          failures++;
          $display("FAIL lsb_idle out=%b last=%b required 0 0 at %0t", out_l, last_l, $time);
        end
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the handshake edge.
  task automatic send(input bit sel, input logic [7:0] w, output int waited);
    bit   rdy;
    exp_t e;
    rdy = 1'b0;
    if (sel) begin
      valid_l = 1'b1;
      data_l  = w;
    end else begin
      valid_m = 1'b1;
      data_m  = w;
    end
    waited = 0;
    while (!rdy && waited < 64) begin
      @(negedge clk);
      waited++;
      rdy = sel ? ready_l : ready_m;
    end
    checks++;
    if (!rdy) begin
      failures++;
      $display("FAIL handshake_timeout sel=%0d in_ready=0 required 1 within 64 cycles", sel);
    end else begin
      for (int i = 0; i < 8; i++) begin
        e.b    = sel ? w[i] : w[7-i];
        e.last = (i == 7);
        if (sel) q_l.push_back(e);
        else q_m.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    if (sel) valid_l = 1'b0;
    else valid_m = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (q_m.size() == 0 && q_l.size() == 0 && !sv_m && !sv_l) done = 1'b1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL drain_timeout pending=%0d/%0d required 0/0", q_m.size(), q_l.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    mon_en = 1'b0;
    #1 rstn = 1'b0;
    #2;
    checks++;
    if ({sv_m, last_m, out_m, ready_m} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_async valid/last/out/ready=%b required 0000",
               {sv_m, last_m, out_m, ready_m});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (ready_m !== 1'b1 || ready_l !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready in_ready=%b/%b required 1/1", ready_m, ready_l);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_msb_basic();
    int v0, l0, w;
    v0 = vcnt_m;
    l0 = lcnt_m;
    send(1'b0, 8'hA5, w);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ready_m !== 1'b0) begin
      failures++;
      $display("FAIL ready_midword in_ready=%b required 0", ready_m);
    end
    @(posedge clk);
    #1;
    drain();
    checks++;
    if (vcnt_m - v0 != 8 || lcnt_m - l0 != 1) begin
      failures++;
      $display("FAIL a5_counts valid=%0d last=%0d required 8 1", vcnt_m - v0, lcnt_m - l0);
    end
  endtask

  task automatic test_lsb_first();
    int v0, l0, w;
    v0 = vcnt_l;
    l0 = lcnt_l;
    send(1'b1, 8'h0F, w);
    drain();
    checks++;
    if (vcnt_l - v0 != 8 || lcnt_l - l0 != 1) begin
      failures++;
      $display("FAIL lsb_counts valid=%0d last=%0d required 8 1", vcnt_l - v0, lcnt_l - l0);
    end
  endtask

  task automatic test_back_to_back();
    int v0, w1, w2;
    v0 = vcnt_m;
    maxrun_m = 0;
    send(1'b0, 8'hFF, w1);
    send(1'b0, 8'h00, w2);
    checks++;
    if (w2 != 8) begin
      failures++;
      $display("FAIL b2b_ready_cycle in_ready seen in cycle %0d required 8", w2);
    end
    drain();
    checks++;
    if (vcnt_m - v0 != 16 || maxrun_m != 16) begin
      failures++;
      $display("FAIL b2b_contiguous valid=%0d run=%0d required 16 16", vcnt_m - v0, maxrun_m);
    end
  endtask

  task automatic test_ser_en();
    int v0, l0, w;
    v0 = vcnt_m;
    l0 = lcnt_m;
    send(1'b0, 8'hC3, w);
    ser_en = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1 ser_en = ~ser_en;
    end
    @(posedge clk);
    #1 ser_en = 1'b1;
    drain();
    checks++;
    if (vcnt_m - v0 != 16 || lcnt_m - l0 != 2) begin
      failures++;
      $display("FAIL seren_counts valid=%0d last=%0d required 16 2", vcnt_m - v0, lcnt_m - l0);
    end
  endtask

  task automatic test_reset_midword();
    int w;
    send(1'b0, 8'hF0, w);
    repeat (3) @(posedge clk);
    mon_en = 1'b0;
    #3 rstn = 1'b0;
    #1;
    checks++;
    if ({sv_m, last_m, out_m, ready_m} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_midword valid/last/out/ready=%b required 0000",
               {sv_m, last_m, out_m, ready_m});
    end
    #2 rstn = 1'b1;
    q_m.delete();
    @(posedge clk);
    #1;
    checks++;
    if (ready_m !== 1'b1) begin
      failures++;
      $display("FAIL reset_midword_ready in_ready=%b required 1", ready_m);
    end
    mon_en = 1'b1;
    send(1'b0, 8'h81, w);
    drain();
  endtask

  task automatic test_data_change();
    int w;
    send(1'b0, 8'hAA, w);
    data_m = 8'h00;
    drain();
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_msb_basic();
    test_lsb_first();
    test_back_to_back();
    test_ser_en();
    test_reset_midword();
    test_data_change();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
